// File: rtl/guess_game_core.sv
// Number-guessing engine: an LFSR picks the secret, synchronised strobes
// drive a four-state game FSM that reports hints, tries and win/lose.
module guess_game_core #(
    parameter int WIDTH = 8,
    parameter int MAX_TRIES = 8,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8,
    parameter logic [WIDTH-1:0] LFSR_SEED = {{(WIDTH-1){1'b0}}, 1'b1},
    localparam int TRY_W = $clog2(MAX_TRIES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             guess_valid,
    input  logic [WIDTH-1:0] guess,
    output logic             hint_hi,
    output logic             hint_lo,
    output logic             win,
    output logic             lose,
    output logic [TRY_W-1:0] tries,
    output logic [WIDTH-1:0] secret_out,
    output logic [1:0]       state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_WIN  = 2'd2;
    localparam logic [1:0] S_LOSE = 2'd3;

    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    logic [2:0]       start_sync;
    logic [2:0]       guess_sync;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] secret;
    logic [1:0]       state_q;
    logic [TRY_W-1:0] tries_q;
    logic             hi_q;
    logic             lo_q;
    logic             start_edge;
    logic             guess_edge;

    // Two-flop synchronisers plus a history flop; run even when disabled
    // so a level held across an enable rise never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync <= '0;
            guess_sync <= '0;
        end else begin
            start_sync <= {start_sync[1:0], start};
            guess_sync <= {guess_sync[1:0], guess_valid};
        end
    end

    assign start_edge = start_sync[1] & ~start_sync[2];
    assign guess_edge = guess_sync[1] & ~guess_sync[2];

    // Galois LFSR, free-running while enabled; never reaches zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (ena) begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
        end
    end

    // Game FSM; start beats a simultaneous guess, guesses only count in PLAY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tries_q <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
            secret  <= '0;
        end else if (ena) begin
            if (start_edge) begin
                secret  <= lfsr;
                tries_q <= '0;
                hi_q    <= 1'b0;
                lo_q    <= 1'b0;
                state_q <= S_PLAY;
            end else if (guess_edge && state_q == S_PLAY) begin
                tries_q <= tries_q + TRY_W'(1);
                if (guess == secret) begin
                    state_q <= S_WIN;
                    hi_q    <= 1'b0;
                    lo_q    <= 1'b0;
                end else begin
                    hi_q <= secret > guess;
                    lo_q <= secret < guess;
                    if (tries_q == LAST_TRY) begin
                        state_q <= S_LOSE;
                    end
                end
            end
        end
    end

    assign state      = state_q;
    assign tries      = tries_q;
    assign hint_hi    = hi_q;
    assign hint_lo    = lo_q;
    assign win        = state_q == S_WIN;
    assign lose       = state_q == S_LOSE;
    assign secret_out = (state_q == S_WIN || state_q == S_LOSE) ? secret : '0;

endmodule

// File: tb/tb_guess_game_core.sv
// Randomised scoreboard bench for guess_game_core: a game-level model
// predicts every output snapshot, a monitor compares them on negedges.
module tb_guess_game_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       guess_valid;
    logic [7:0] guess;
    logic       hint_hi;
    logic       hint_lo;
    logic       win;
    logic       lose;
    logic [3:0] tries;
    logic [7:0] secret_out;
    logic [1:0] state;

    guess_game_core dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .start(start),
        .guess_valid(guess_valid),
        .guess(guess),
        .hint_hi(hint_hi),
        .hint_lo(hint_lo),
        .win(win),
        .lose(lose),
        .tries(tries),
        .secret_out(secret_out),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          cyc;
        int          tag;
        logic [17:0] v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   cnt;
    logic [7:0] seq [0:254];

    int         mstate;
    int         mtries;
    logic       mhi;
    logic       mlo;
    logic [7:0] msecret;
    int         lo_b;
    int         hi_b;

    // Bench cycle counter for scheduling expectations.
    always @(posedge clk) cyc <= cyc + 1;

    // Number of enabled clock edges since reset: indexes the LFSR sequence.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 0;
        else if (ena) cnt <= cnt + 1;
    end

    function automatic logic [17:0] model_vec();
        logic [7:0] s;
        s = (mstate >= 2) ? msecret : 8'd0;
        return {mstate[1:0], mstate == 2, mstate == 3, mhi, mlo,
                mtries[3:0], s};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {state, win, lose, hint_hi, hint_lo, tries, secret_out};
    endfunction

    task automatic check(input string nm, input logic [17:0] a,
                         input logic [17:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got st=%0d w=%0b l=%0b hi=%0b lo=%0b tr=%0d sec=%0d want st=%0d w=%0b l=%0b hi=%0b lo=%0b tr=%0d sec=%0d",
                     nm, a[17:16], a[15], a[14], a[13], a[12], a[11:8], a[7:0],
                     e[17:16], e[15], e[14], e[13], e[12], e[11:8], e[7:0]);
        end
    endtask

    // Monitor: pop every expectation whose cycle has come and compare.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            check($sformatf("step%0d", e.tag), dut_vec(), e.v);
        end
    end

    int tag = 0;

    task automatic push(input int at);
        exp_t e;
        e.cyc = at;
        e.tag = tag;
        e.v = model_vec();
        q.push_back(e);
    endtask

    task automatic model_reset();
        mstate = 0;
        mtries = 0;
        mhi = 1'b0;
        mlo = 1'b0;
        msecret = 8'd0;
    endtask

    task automatic expect_next();
        @(negedge clk);
        tag++;
        push(cyc + 1);
    endtask

    // One strobe: rise at a negedge, held 4 cycles, then low for 4.
    task automatic pulse(input logic do_s, input logic do_g,
                         input logic [7:0] g);
        int c;
        @(negedge clk);
        c = cyc;
        tag++;
        guess = g;
        push(c + 2);
        if (do_s) begin
            msecret = seq[(cnt + 2) % 255];
            mstate = 1;
            mtries = 0;
            mhi = 1'b0;
            mlo = 1'b0;
            lo_b = 1;
            hi_b = 255;
        end else if (do_g && mstate == 1) begin
            mtries++;
            if (g == msecret) begin
                mstate = 2;
                mhi = 1'b0;
                mlo = 1'b0;
            end else begin
                mhi = msecret > g;
                mlo = msecret < g;
                if (mhi) lo_b = int'(g) + 1;
                if (mlo) hi_b = int'(g) - 1;
                if (mtries == 8) mstate = 3;
            end
        end
        push(c + 3);
        start = do_s;
        guess_valid = do_g;
        repeat (4) @(negedge clk);
        start = 1'b0;
        guess_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic bisect_step();
        pulse(1'b0, 1'b1, 8'((lo_b + hi_b) / 2));
    endtask

    initial begin
        logic [7:0] v;
        int r;
        v = 8'd1;
        for (int i = 0; i < 255; i++) begin
            seq[i] = v;
            v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
        end
        lo_b = 1;
        hi_b = 255;
        model_reset();
        rst_n = 1'b0;
        ena = 1'b1;
        start = 1'b0;
        guess_valid = 1'b0;
        guess = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_next();

        // latency and guess ignored in IDLE
        pulse(1'b0, 1'b1, 8'd7);
        pulse(1'b1, 1'b0, 8'd0);
        pulse(1'b0, 1'b1, 8'd0);

        // lose with eight guesses of zero, then a guess ignored in LOSE
        pulse(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 8; i++) pulse(1'b0, 1'b1, 8'd0);
        pulse(1'b0, 1'b1, 8'd5);

        // bisection win
        pulse(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 10 && mstate == 1; i++) bisect_step();
        pulse(1'b0, 1'b1, 8'd3);

        // start and guess together with three tries used
        pulse(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, msecret ^ 8'h01);
        pulse(1'b1, 1'b1, msecret);

        // disabled: strobes discarded, held level across enable rise
        @(negedge clk);
        ena = 1'b0;
        start = 1'b1;
        guess_valid = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        guess_valid = 1'b0;
        repeat (4) @(negedge clk);
        expect_next();
        start = 1'b1;
        repeat (4) @(negedge clk);
        ena = 1'b1;
        repeat (4) @(negedge clk);
        expect_next();
        start = 1'b0;
        repeat (4) @(negedge clk);
        pulse(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 10 && mstate == 1; i++) bisect_step();

        // asynchronous reset mid-game with a start in flight
        pulse(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, msecret ^ 8'h01);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("reset_async", dut_vec(), model_vec());
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        expect_next();

        // randomised play
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) pulse(1'b1, 1'b0, 8'($urandom_range(0, 255)));
            else if (r == 1) pulse(1'b1, 1'b1, 8'($urandom_range(0, 255)));
            else if (r < 6 && mstate == 1) bisect_step();
            else pulse(1'b0, 1'b1, 8'($urandom_range(0, 255)));
        end

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
